// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer and its target generator.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam int kFetchResetPc = 0;

endpackage

// File: rtl/fetch_target_gen.sv
// Combinational redirect decision and target address for branches and JALR.
module fetch_target_gen
    import fetch_sequencer_pkg::*;
#(
    parameter int IMEM_ADDR_W = 10,
    parameter int BR_OFF_W    = 8
) (
    input  logic                   stall_i,
    input  logic                   branch_i,
    input  logic                   jump_now_i,
    input  logic                   jalr_i,
    input  logic [IMEM_ADDR_W-1:0] branch_base_i,
    input  logic [BR_OFF_W-1:0]    branch_off_i,
    input  logic [31:0]            jalr_target_i,
    output logic                   redirect_o,
    output logic [IMEM_ADDR_W-1:0] target_o
);

    function automatic logic [IMEM_ADDR_W-1:0] sext_off(input logic signed [BR_OFF_W-1:0] off);
        logic signed [IMEM_ADDR_W-1:0] ext;
        ext = IMEM_ADDR_W'(off);
        return ext;
    endfunction

    logic [IMEM_ADDR_W-1:0] br_target_d;
    logic                   unused_jalr_hi;

    // Only the word-address bits of the ALU result are meaningful to I-mem.
    assign unused_jalr_hi = ^jalr_target_i[31:IMEM_ADDR_W];

    assign br_target_d = branch_base_i + sext_off(branch_off_i);
    assign target_o    = jalr_i ? jalr_target_i[IMEM_ADDR_W-1:0] : br_target_d;
    assign redirect_o  = !stall_i && ((branch_i && jump_now_i) || jalr_i);

endmodule

// File: rtl/fetch_sequencer.sv
// PC generator and fetch-control FSM; FETCH_REDIRECT_CNT_EN adds a redirect counter output.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int IMEM_ADDR_W = 10,
    parameter int BR_OFF_W    = 8
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   start_i,
    input  logic [IMEM_ADDR_W-1:0] start_pc_i,
    input  logic                   halt_i,
    input  logic                   stall_i,
    input  logic                   jump_now_i,
    input  logic                   branch_i,
    input  logic [IMEM_ADDR_W-1:0] branch_base_i,
    input  logic [BR_OFF_W-1:0]    branch_off_i,
    input  logic                   jalr_i,
    input  logic [31:0]            jalr_target_i,
    output logic [IMEM_ADDR_W-1:0] pc_o,
    output logic                   fetch_valid_o,
    output logic                   flush_o,
    output logic [1:0]             state_o
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    output logic [31:0]            redirect_cnt_o
`endif
);

    fetch_state_e           state_q;
    logic [IMEM_ADDR_W-1:0] pc_q;
    logic [IMEM_ADDR_W-1:0] pc_inc_d;
    logic                   valid_q;
    logic                   redirect_d;
    logic [IMEM_ADDR_W-1:0] target_d;
`ifdef FETCH_REDIRECT_CNT_EN
    logic [31:0]            cnt_q;
`endif

    fetch_target_gen #(
        .IMEM_ADDR_W (IMEM_ADDR_W),
        .BR_OFF_W    (BR_OFF_W)
    ) u_target_gen (
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .jump_now_i    (jump_now_i),
        .jalr_i        (jalr_i),
        .branch_base_i (branch_base_i),
        .branch_off_i  (branch_off_i),
        .jalr_target_i (jalr_target_i),
        .redirect_o    (redirect_d),
        .target_o      (target_d)
    );

    assign pc_inc_d = pc_q + 1'b1;

    // Halt outranks a redirect, so the squash only fires when the redirect is accepted.
    assign flush_o = n_reset && (state_q == RUN) && !halt_i && redirect_d;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
            pc_q    <= IMEM_ADDR_W'(kFetchResetPc);
            valid_q <= 1'b0;
`ifdef FETCH_REDIRECT_CNT_EN
            cnt_q   <= 32'd0;
`endif
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (start_i) begin
                        pc_q    <= start_pc_i;
                        valid_q <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt_i) begin
                        valid_q <= 1'b0;
                        state_q <= HALT;
                    end else if (redirect_d) begin
                        pc_q    <= target_d;
                        valid_q <= 1'b0;
                        state_q <= FLUSH;
`ifdef FETCH_REDIRECT_CNT_EN
                        cnt_q   <= cnt_q + 32'd1;
`endif
                    end else if (!stall_i) begin
                        pc_q    <= pc_inc_d;
                        valid_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (halt_i) begin
                        valid_q <= 1'b0;
                        state_q <= HALT;
                    end else begin
                        pc_q    <= pc_inc_d;
                        valid_q <= 1'b1;
                        state_q <= RUN;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = valid_q;
    assign state_o       = state_q;
`ifdef FETCH_REDIRECT_CNT_EN
    assign redirect_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; FETCH_REDIRECT_CNT_EN enables counter checks.
module tb_fetch_sequencer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start_i;
    logic [9:0]  start_pc_i;
    logic        halt_i;
    logic        stall_i;
    logic        jump_now_i;
    logic        branch_i;
    logic [9:0]  branch_base_i;
    logic [7:0]  branch_off_i;
    logic        jalr_i;
    logic [31:0] jalr_target_i;
    logic [9:0]  pc_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic [1:0]  state_o;
`ifdef FETCH_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_sequencer #(
        .IMEM_ADDR_W (10),
        .BR_OFF_W    (8)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .start_i        (start_i),
        .start_pc_i     (start_pc_i),
        .halt_i         (halt_i),
        .stall_i        (stall_i),
        .jump_now_i     (jump_now_i),
        .branch_i       (branch_i),
        .branch_base_i  (branch_base_i),
        .branch_off_i   (branch_off_i),
        .jalr_i         (jalr_i),
        .jalr_target_i  (jalr_target_i),
        .pc_o           (pc_o),
        .fetch_valid_o  (fetch_valid_o),
        .flush_o        (flush_o),
        .state_o        (state_o)
`ifdef FETCH_REDIRECT_CNT_EN
        ,
        .redirect_cnt_o (redirect_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        start_i    = 1'b0;
        halt_i     = 1'b0;
        stall_i    = 1'b0;
        jump_now_i = 1'b0;
        branch_i   = 1'b0;
        jalr_i     = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [9:0] pc, input logic vld, input logic [1:0] st);
        check({tag, ".pc"},    32'(pc_o),          32'(pc));
        check({tag, ".valid"}, 32'(fetch_valid_o), 32'(vld));
        check({tag, ".state"}, 32'(state_o),       32'(st));
    endtask

    initial begin
        n_reset       = 1'b0;
        start_pc_i    = 10'h000;
        branch_base_i = 10'h000;
        branch_off_i  = 8'h00;
        jalr_target_i = 32'h0;
        clear_ctl();
        step();
        step();
        check_regs("reset", 10'h000, 1'b0, S_IDLE);
        check("reset.flush", 32'(flush_o), 32'd0);

        n_reset = 1'b1;
        step();
        check_regs("idle", 10'h000, 1'b0, S_IDLE);

        // Start at 0x010 and run sequentially
        start_i = 1'b1; start_pc_i = 10'h010;
        step();
        start_i = 1'b0;
        check_regs("start0", 10'h010, 1'b1, S_RUN);
        step();
        check_regs("start1", 10'h011, 1'b1, S_RUN);
        step();
        check_regs("start2", 10'h012, 1'b1, S_RUN);

        // Taken branch backwards: 0x020 + (-4) = 0x01C
        branch_i = 1'b1; jump_now_i = 1'b1; branch_base_i = 10'h020; branch_off_i = 8'hFC;
        #1;
        check("br.flush", 32'(flush_o), 32'd1);
        step();
        clear_ctl();
        check_regs("br.bubble", 10'h01C, 1'b0, S_FLUSH);
        check("br.flush_low", 32'(flush_o), 32'd0);
        step();
        check_regs("br.resume", 10'h01D, 1'b1, S_RUN);

        // Not-taken branch just increments
        branch_i = 1'b1; jump_now_i = 1'b0;
        #1;
        check("nt.flush", 32'(flush_o), 32'd0);
        step();
        clear_ctl();
        check_regs("nt", 10'h01E, 1'b1, S_RUN);

        // JALR with junk upper bits, landing on last word then wrapping
        jalr_i = 1'b1; jalr_target_i = 32'hFFFF_F3FF;
        #1;
        check("jalr.flush", 32'(flush_o), 32'd1);
        step();
        clear_ctl();
        check_regs("jalr", 10'h3FF, 1'b0, S_FLUSH);
        step();
        check_regs("jalr.wrap", 10'h000, 1'b1, S_RUN);

        // JALR and taken branch together: JALR target wins
        jalr_i = 1'b1; jalr_target_i = 32'h0000_0050;
        branch_i = 1'b1; jump_now_i = 1'b1; branch_base_i = 10'h020; branch_off_i = 8'h04;
        step();
        clear_ctl();
        check_regs("both", 10'h050, 1'b0, S_FLUSH);
        step();
        check_regs("both.resume", 10'h051, 1'b1, S_RUN);

        // Stall for 3 cycles with a taken branch presented (target 0x100 + 8)
        stall_i = 1'b1; branch_i = 1'b1; jump_now_i = 1'b1; branch_base_i = 10'h100; branch_off_i = 8'h08;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.flush", 32'(flush_o), 32'd0);
            step();
            check_regs("stall", 10'h051, 1'b1, S_RUN);
        end
        stall_i = 1'b0;
        #1;
        check("unstall.flush", 32'(flush_o), 32'd1);
        step();
        clear_ctl();
        check_regs("unstall", 10'h108, 1'b0, S_FLUSH);
        step();
        check_regs("unstall.resume", 10'h109, 1'b1, S_RUN);

        // Halt in RUN, then restart at 0x100
        halt_i = 1'b1; jalr_i = 1'b1; jalr_target_i = 32'h0000_0222;
        #1;
        check("halt.noflush", 32'(flush_o), 32'd0);
        step();
        clear_ctl();
        check_regs("halt", 10'h109, 1'b0, S_HALT);
        step();
        check_regs("halt.hold", 10'h109, 1'b0, S_HALT);
        start_i = 1'b1; start_pc_i = 10'h100;
        step();
        start_i = 1'b0;
        check_regs("restart", 10'h100, 1'b1, S_RUN);
        step();
        check_regs("restart1", 10'h101, 1'b1, S_RUN);

        // Halt arriving during the FLUSH bubble
        jalr_i = 1'b1; jalr_target_i = 32'h0000_0200;
        step();
        clear_ctl();
        check_regs("hf.flush", 10'h200, 1'b0, S_FLUSH);
        halt_i = 1'b1;
        step();
        clear_ctl();
        check_regs("hf.halt", 10'h200, 1'b0, S_HALT);

        // start_i while running is ignored
        start_i = 1'b1; start_pc_i = 10'h010;
        step();
        start_pc_i = 10'h3AA;
        step();
        start_i = 1'b0;
        check_regs("start_in_run", 10'h011, 1'b1, S_RUN);

`ifdef FETCH_REDIRECT_CNT_EN
        check("cnt5", redirect_cnt_o, 32'd5);
`endif

        // Mid-run reset with a redirect presented: flush stays low, everything clears
        n_reset = 1'b0; jalr_i = 1'b1; jalr_target_i = 32'h0000_0123;
        #1;
        check("rst.flush_forced", 32'(flush_o), 32'd0);
        step();
        check_regs("midrst", 10'h000, 1'b0, S_IDLE);
        check("midrst.flush", 32'(flush_o), 32'd0);
`ifdef FETCH_REDIRECT_CNT_EN
        check("cnt.rst", redirect_cnt_o, 32'd0);
`endif
        clear_ctl();
        n_reset = 1'b1;
        step();
        check_regs("post_rst", 10'h000, 1'b0, S_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
